// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM request arbiter and its counters.
package sram_pkg;

    localparam int DEFAULT_ADDR_W = 18;
    localparam int DEFAULT_DATA_W = 16;

    // Every bit of the read data returned on a timed-out access takes this value.
    localparam logic ERR_FILL_BIT = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } arbState_t;

    // Number of bits needed to hold the values 0..maxVal (at least one bit).
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/sram_arb_timer.sv
// Clearable saturating up-counter with a terminal-count flag.
// The counter stops at MAX_CNT; tc_o is high whenever the count equals TC_AT.
module sram_arb_timer
    import sram_pkg::*;
#(
    parameter int MAX_CNT = 15,
    parameter int TC_AT   = MAX_CNT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam int W = cntWidth(MAX_CNT);
    localparam logic [W-1:0] MAX_V = W'(MAX_CNT);
    localparam logic [W-1:0] TC_V  = W'(TC_AT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over increment; the count holds once it reaches MAX_CNT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_V);

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the CPU instruction-fetch and data-memory ports onto the single
// request/acknowledge interface of the SRAM pin controller. MEM normally wins,
// IF is forced through after STARVE_LIMIT back-to-back MEM grants, and an access
// that sees no acknowledge for TIMEOUT busy cycles is aborted with bus_err.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,

    output logic              sram_req,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_ack,

    output logic              bus_err
);

    localparam logic [DATA_W-1:0] ERR_RDATA = {DATA_W{ERR_FILL_BIT}};

    arbState_t         state_q;
    logic              sramReq_q;
    logic              sramWe_q;
    logic [ADDR_W-1:0] sramAddr_q;
    logic [DATA_W-1:0] sramWdata_q;
    logic [DATA_W-1:0] ifRdata_q;
    logic [DATA_W-1:0] memRdata_q;
    logic              ifReady_q;
    logic              memReady_q;
    logic              busErr_q;

    logic isIdle;
    logic isBusy;
    logic grantIf;
    logic grantMem;
    logic starveHit;
    logic starveClr;
    logic starveInc;
    logic timeoutHit;
    logic timeoutAbort;
    logic timeoutInc;

    // Grant decision in IDLE: MEM first unless IF has been passed over too often.
    always_comb begin
        isIdle       = (state_q == IDLE);
        isBusy       = (state_q == BUSY_IF) || (state_q == BUSY_MEM);
        grantIf      = isIdle && if_req && (!mem_req || starveHit);
        grantMem     = isIdle && mem_req && !grantIf;
        starveClr    = !if_req || grantIf;
        starveInc    = grantMem && if_req;
        timeoutInc   = isBusy && !sram_ack;
        timeoutAbort = timeoutInc && timeoutHit;
    end

    // Consecutive MEM grants while IF waits; saturates at STARVE_LIMIT.
    sram_arb_timer #(
        .MAX_CNT (STARVE_LIMIT),
        .TC_AT   (STARVE_LIMIT)
    ) u_starve (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (starveClr),
        .inc_i (starveInc),
        .tc_o  (starveHit)
    );

    // Busy cycles without acknowledge; flags the cycle whose increment reaches
    // TIMEOUT so the abort lands on that same edge.
    sram_arb_timer #(
        .MAX_CNT (TIMEOUT),
        .TC_AT   (TIMEOUT - 1)
    ) u_timeout (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (grantIf || grantMem),
        .inc_i (timeoutInc),
        .tc_o  (timeoutHit)
    );

    // Arbitration FSM with all controller-side and master-side outputs registered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            sramReq_q   <= 1'b0;
            sramWe_q    <= 1'b0;
            sramAddr_q  <= '0;
            sramWdata_q <= '0;
            ifRdata_q   <= '0;
            memRdata_q  <= '0;
            ifReady_q   <= 1'b0;
            memReady_q  <= 1'b0;
            busErr_q    <= 1'b0;
        end else begin
            ifReady_q  <= 1'b0;
            memReady_q <= 1'b0;
            busErr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grantIf) begin
                        state_q    <= BUSY_IF;
                        sramReq_q  <= 1'b1;
                        sramWe_q   <= 1'b0;
                        sramAddr_q <= if_addr;
                    end else if (grantMem) begin
                        state_q     <= BUSY_MEM;
                        sramReq_q   <= 1'b1;
                        sramWe_q    <= mem_we;
                        sramAddr_q  <= mem_addr;
                        sramWdata_q <= mem_wdata;
                    end
                end
                BUSY_IF: begin
                    if (sram_ack) begin
                        state_q   <= IDLE;
                        sramReq_q <= 1'b0;
                        ifRdata_q <= sram_rdata;
                        ifReady_q <= 1'b1;
                    end else if (timeoutAbort) begin
                        state_q   <= IDLE;
                        sramReq_q <= 1'b0;
                        ifRdata_q <= ERR_RDATA;
                        ifReady_q <= 1'b1;
                        busErr_q  <= 1'b1;
                    end
                end
                BUSY_MEM: begin
                    if (sram_ack) begin
                        state_q    <= IDLE;
                        sramReq_q  <= 1'b0;
                        memReady_q <= 1'b1;
                        if (!sramWe_q) begin
                            memRdata_q <= sram_rdata;
                        end
                    end else if (timeoutAbort) begin
                        state_q    <= IDLE;
                        sramReq_q  <= 1'b0;
                        memRdata_q <= ERR_RDATA;
                        memReady_q <= 1'b1;
                        busErr_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    sramReq_q <= 1'b0;
                end
            endcase
        end
    end

    assign sram_req   = sramReq_q;
    assign sram_we    = sramWe_q;
    assign sram_addr  = sramAddr_q;
    assign sram_wdata = sramWdata_q;
    assign if_rdata   = ifRdata_q;
    assign if_ready   = ifReady_q;
    assign mem_rdata  = memRdata_q;
    assign mem_ready  = memReady_q;
    assign bus_err    = busErr_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter: two master drivers and a controller model
// with random latencies (including never-acknowledge) against a transaction-level
// reference of the arbitration, starvation and timeout rules.
module tb_sram_arbiter;

    localparam int ADDR_W       = 18;
    localparam int DATA_W       = 16;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 15;

    logic              CLK = 1'b0;
    logic              RST;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              sram_req;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_ack;
    logic              bus_err;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference: who owns the controller (0 none, 1 IF, 2 MEM), busy cycles so far,
    // chosen acknowledge cycle, and MEM grants IF has sat through.
    int mOwner;
    int mBusy;
    int mLat;
    int mStarve;

    logic              eReq;
    logic              eWe;
    logic [ADDR_W-1:0] eAddr;
    logic [DATA_W-1:0] eWdata;
    logic [DATA_W-1:0] eIfRdata;
    logic [DATA_W-1:0] eMemRdata;
    logic              eIfReady;
    logic              eMemReady;
    logic              eBusErr;

    bit ifOut;
    bit memOut;
    int ifPct;
    int memPct;

    sram_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .sram_req   (sram_req),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_ack   (sram_ack),
        .bus_err    (bus_err)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: observed %h, expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic resetModel();
        mOwner    = 0;
        mBusy     = 0;
        mLat      = 0;
        mStarve   = 0;
        eReq      = 1'b0;
        eWe       = 1'b0;
        eAddr     = '0;
        eWdata    = '0;
        eIfRdata  = '0;
        eMemRdata = '0;
        eIfReady  = 1'b0;
        eMemReady = 1'b0;
        eBusErr   = 1'b0;
    endtask

    task automatic checkResetValues();
        checkOutput("rstReq",       32'(sram_req),   32'd0);
        checkOutput("rstWe",        32'(sram_we),    32'd0);
        checkOutput("rstAddr",      32'(sram_addr),  32'd0);
        checkOutput("rstWdata",     32'(sram_wdata), 32'd0);
        checkOutput("rstIfReady",   32'(if_ready),   32'd0);
        checkOutput("rstMemReady",  32'(mem_ready),  32'd0);
        checkOutput("rstBusErr",    32'(bus_err),    32'd0);
        checkOutput("rstIfRdata",   32'(if_rdata),   32'd0);
        checkOutput("rstMemRdata",  32'(mem_rdata),  32'd0);
    endtask

    task automatic checkAll();
        checkOutput("sramReq",  32'(sram_req),  32'(eReq));
        checkOutput("ifReady",  32'(if_ready),  32'(eIfReady));
        checkOutput("memReady", 32'(mem_ready), 32'(eMemReady));
        checkOutput("busErr",   32'(bus_err),   32'(eBusErr));
        checkOutput("ifRdata",  32'(if_rdata),  32'(eIfRdata));
        checkOutput("memRdata", 32'(mem_rdata), 32'(eMemRdata));
        if (eReq) begin
            checkOutput("sramWe",   32'(sram_we),   32'(eWe));
            checkOutput("sramAddr", 32'(sram_addr), 32'(eAddr));
            if (eWe) begin
                checkOutput("sramWdata", 32'(sram_wdata), 32'(eWdata));
            end
        end
    endtask

    // Controller response time in busy cycles; 40 means it never answers.
    function automatic int pickLatency();
        int r;
        r = int'($urandom_range(9));
        if (r == 0) return 40;
        if (r == 1) return TIMEOUT;
        if (r == 2) return TIMEOUT - 1;
        return 1 + int'($urandom_range(3));
    endfunction

    // Masters raise level requests and hold them until their ready is seen;
    // the controller answers on its chosen cycle and sometimes acks stray.
    task automatic applyStimulus();
        if (eIfReady) ifOut = 1'b0;
        if (!ifOut) begin
            if (int'($urandom_range(99)) < ifPct) begin
                ifOut   = 1'b1;
                if_req  = 1'b1;
                if_addr = ADDR_W'($urandom);
            end else begin
                if_req = 1'b0;
            end
        end
        if (eMemReady) memOut = 1'b0;
        if (!memOut) begin
            if (int'($urandom_range(99)) < memPct) begin
                memOut    = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'($urandom_range(1));
                mem_addr  = ADDR_W'($urandom);
                mem_wdata = DATA_W'($urandom);
            end else begin
                mem_req = 1'b0;
            end
        end
        if (mOwner != 0) begin
            sram_ack = (mBusy + 1 == mLat);
        end else begin
            sram_ack = (int'($urandom_range(99)) < 8);
        end
        sram_rdata = DATA_W'($urandom);
    endtask

    // Effect of the coming clock edge on the reference, from current inputs.
    task automatic modelStep();
        bit ifWins;
        bit memWins;
        eIfReady  = 1'b0;
        eMemReady = 1'b0;
        eBusErr   = 1'b0;
        if (mOwner == 0) begin
            ifWins  = if_req && (!mem_req || mStarve == STARVE_LIMIT);
            memWins = mem_req && !ifWins;
            if (ifWins) begin
                mOwner  = 1;
                eReq    = 1'b1;
                eWe     = 1'b0;
                eAddr   = if_addr;
                mStarve = 0;
            end else if (memWins) begin
                mOwner = 2;
                eReq   = 1'b1;
                eWe    = mem_we;
                eAddr  = mem_addr;
                eWdata = mem_wdata;
                if (if_req && mStarve < STARVE_LIMIT) mStarve++;
            end
            if (ifWins || memWins) begin
                mBusy = 0;
                mLat  = pickLatency();
            end
        end else begin
            mBusy++;
            if (sram_ack) begin
                eReq = 1'b0;
                if (mOwner == 1) begin
                    eIfReady = 1'b1;
                    eIfRdata = sram_rdata;
                end else begin
                    eMemReady = 1'b1;
                    if (!eWe) eMemRdata = sram_rdata;
                end
                mOwner = 0;
            end else if (mBusy == TIMEOUT) begin
                eReq    = 1'b0;
                eBusErr = 1'b1;
                if (mOwner == 1) begin
                    eIfReady = 1'b1;
                    eIfRdata = '1;
                end else begin
                    eMemReady = 1'b1;
                    eMemRdata = '1;
                end
                mOwner = 0;
            end
        end
        if (!if_req) mStarve = 0;
    endtask

    task automatic stepCycle();
        @(negedge CLK);
        checkAll();
        applyStimulus();
        modelStep();
    endtask

    // Hard stop in case the clock or scheduling ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog at %0t: observed timeout, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reset, random traffic, forced contention, reset mid-access, more traffic.
    initial begin
        RST        = 1'b1;
        if_req     = 1'b0;
        if_addr    = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        sram_rdata = '0;
        sram_ack   = 1'b0;
        ifOut      = 1'b0;
        memOut     = 1'b0;
        ifPct      = 60;
        memPct     = 60;
        resetModel();

        #2;
        checkResetValues();
        @(negedge CLK);
        checkResetValues();
        RST = 1'b0;

        repeat (600) stepCycle();

        ifPct  = 100;
        memPct = 100;
        repeat (150) stepCycle();

        ifPct  = 40;
        memPct = 90;
        for (int i = 0; i < 300; i++) begin
            stepCycle();
            if (mOwner == 2) break;
        end
        checkOutput("resetSetupOwner", 32'(mOwner), 32'd2);
        @(posedge CLK);
        #1;
        checkOutput("preResetReq", 32'(sram_req), 32'(eReq));
        RST = 1'b1;
        #1;
        resetModel();
        checkResetValues();
        if_req   = 1'b0;
        mem_req  = 1'b0;
        sram_ack = 1'b0;
        ifOut    = 1'b0;
        memOut   = 1'b0;
        @(negedge CLK);
        checkResetValues();
        RST = 1'b0;

        ifPct  = 60;
        memPct = 50;
        repeat (300) stepCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
